// File: rtl/ifetch_prefetch.sv
// Instruction fetch/prefetch unit: issues one ROM request at a time, buffers
// returned words in a small FIFO and hands them to decode; redirects flush and restart.
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ins_valid,
  output logic [15:0] ins_data,
  output logic [15:0] ins_pc,
  input  logic        ins_ack
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state;
  logic [15:0]   pc;
  logic [15:0]   req_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   data_mem [DEPTH];
  logic [15:0]   pc_mem   [DEPTH];
  logic          push;
  logic          pop;
  logic          flush;

  // A redirect kills any same-cycle response, so push never coincides with flush.
  always_comb begin
    flush = redirect;
    push  = (state == WAIT) && mem_valid && !redirect;
    pop   = ins_ack && (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (count < FULL) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
            req_pc   <= pc;
            pc       <= pc + 16'd1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= mem_valid ? IDLE : DROP;
          end else if (mem_valid) begin
            state <= IDLE;
          end
        end
        DROP: begin
          if (redirect) pc <= redirect_pc;
          if (mem_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      data_mem <= '{default: '0};
      pc_mem   <= '{default: '0};
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= mem_data;
        pc_mem[wr_ptr]   <= req_pc;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign ins_valid = (count != '0);
  assign ins_data  = data_mem[rd_ptr];
  assign ins_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch: directed phases push expected requests and
// deliveries into queues; a negedge monitor pops and compares them.
module tb_ifetch_prefetch;

  typedef struct {
    logic [15:0] addr;
    int          gap;
  } req_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } ins_t;

  logic        clk;
  logic        rst1, rst2, sel;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ins_ack;

  logic        mem_req1, mem_req2, ins_valid1, ins_valid2;
  logic [15:0] mem_addr1, mem_addr2, ins_data1, ins_data2, ins_pc1, ins_pc2;
  logic        m_req, m_ins_valid;
  logic [15:0] m_addr, m_ins_data, m_ins_pc;

  int   n_checks, n_fail, cyc, lat, last_req;
  req_t exp_addr[$];
  ins_t exp_ins[$];
  req_t rom_q[$];
  req_t mon_r;
  ins_t mon_i;
  req_t rom_e;

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut1 (
    .clk(clk), .rst(rst1), .mem_req(mem_req1), .mem_addr(mem_addr1),
    .mem_data(mem_data), .mem_valid(mem_valid), .redirect(redirect),
    .redirect_pc(redirect_pc), .ins_valid(ins_valid1), .ins_data(ins_data1),
    .ins_pc(ins_pc1), .ins_ack(ins_ack));

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst2), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_data(mem_data), .mem_valid(mem_valid), .redirect(redirect),
    .redirect_pc(redirect_pc), .ins_valid(ins_valid2), .ins_data(ins_data2),
    .ins_pc(ins_pc2), .ins_ack(ins_ack));

  assign m_req       = sel ? mem_req2   : mem_req1;
  assign m_addr      = sel ? mem_addr2  : mem_addr1;
  assign m_ins_valid = sel ? ins_valid2 : ins_valid1;
  assign m_ins_data  = sel ? ins_data2  : ins_data1;
  assign m_ins_pc    = sel ? ins_pc2    : ins_pc1;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input logic [15:0] a, input int gap);
    req_t r;
    r.addr = a;
    r.gap  = gap;
    exp_addr.push_back(r);
  endtask

  task automatic push_ins(input logic [15:0] p);
    ins_t i;
    i.pc   = p;
    i.data = rom(p);
    exp_ins.push_back(i);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_addr.size() == 0 && exp_ins.size() == 0) break;
      tick();
    end
    check("drain", 32'(exp_addr.size() + exp_ins.size()), 32'd0);
  endtask

  task automatic assert_reset();
    rst1 = 1'b1;
    rst2 = 1'b1;
    repeat (3) tick();
    rom_q.delete();
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ROM model: fixed latency in cycles from the cycle mem_req is seen high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      while (rom_q.size() != 0 && rom_q[0].gap < cyc) void'(rom_q.pop_front());
      if (rom_q.size() != 0 && rom_q[0].gap == cyc) begin
        rom_e     = rom_q.pop_front();
        mem_valid = 1'b1;
        mem_data  = rom(rom_e.addr);
      end
      if (m_req) begin
        rom_e.addr = m_addr;
        rom_e.gap  = cyc + lat;
        rom_q.push_back(rom_e);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_req) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got request to %h, required none (cycle %0d)", m_addr, cyc);
        end else begin
          mon_r = exp_addr.pop_front();
          check("mem_addr", 32'(m_addr), 32'(mon_r.addr));
          if (mon_r.gap != 0) check("req_gap", 32'(cyc - last_req), 32'(mon_r.gap));
        end
        last_req = cyc;
      end
      if (m_ins_valid && ins_ack) begin
        if (exp_ins.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ins: got pc %h data %h, required none (cycle %0d)", m_ins_pc, m_ins_data, cyc);
        end else begin
          mon_i = exp_ins.pop_front();
          check("ins_pc", 32'(m_ins_pc), 32'(mon_i.pc));
          check("ins_data", 32'(m_ins_data), 32'(mon_i.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; last_req = 0; lat = 1;
    rst1 = 1'b1; rst2 = 1'b1; sel = 1'b0;
    redirect = 1'b0; redirect_pc = '0; ins_ack = 1'b0;
    mem_valid = 1'b0; mem_data = '0;

    // Reset values, then streaming at ROM latency 1 with ack held high.
    repeat (3) tick();
    check("rst_mem_req", 32'(mem_req1), 32'd0);
    check("rst_mem_addr", 32'(mem_addr1), 32'd0);
    check("rst_ins_valid", 32'(ins_valid1), 32'd0);
    check("rst_ins_data", 32'(ins_data1), 32'd0);
    check("rst_ins_pc", 32'(ins_pc1), 32'd0);
    lat = 1; ins_ack = 1'b1;
    push_req(16'd0, 0);
    for (int k = 1; k <= 6; k++) push_req(16'(k), 3);
    for (int k = 0; k <= 5; k++) push_ins(16'(k));
    rst1 = 1'b0;
    wait_drain(60);

    // FIFO fill with no ack, latency 2: four requests then stall.
    assert_reset();
    lat = 2; ins_ack = 1'b0;
    for (int k = 0; k <= 3; k++) push_req(16'(k), 0);
    rst1 = 1'b0;
    repeat (30) tick();
    check("full_drain", 32'(exp_addr.size()), 32'd0);
    check("full_valid", 32'(ins_valid1), 32'd1);
    check("full_head_pc", 32'(ins_pc1), 32'h0000);
    check("full_head_data", 32'(ins_data1), 32'(rom(16'h0000)));
    push_req(16'd4, 0);
    push_ins(16'd0);
    ins_ack = 1'b1;
    tick();
    ins_ack = 1'b0;
    wait_drain(20);
    repeat (10) tick();
    check("after_ack_head_pc", 32'(ins_pc1), 32'h0001);
    check("after_ack_head_data", 32'(ins_data1), 32'(rom(16'h0001)));

    // Redirect to 0x0040 while WAIT with a non-empty FIFO, latency 3.
    assert_reset();
    lat = 3; ins_ack = 1'b0;
    push_req(16'h0000, 0);
    push_req(16'h0001, 5);
    push_req(16'h0040, 5);
    push_req(16'h0041, 5);
    push_req(16'h0042, 5);
    push_ins(16'h0040);
    push_ins(16'h0041);
    rst1 = 1'b0;
    repeat (6) tick();
    check("pre_redirect_valid", 32'(ins_valid1), 32'd1);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("flush_valid", 32'(ins_valid1), 32'd0);
    ins_ack = 1'b1;
    wait_drain(60);

    // Redirect on the same edge as mem_valid, latency 1.
    assert_reset();
    lat = 1; ins_ack = 1'b1;
    push_req(16'h0000, 0);
    push_req(16'h0100, 3);
    push_req(16'h0101, 3);
    push_ins(16'h0100);
    rst1 = 1'b0;
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    check("same_edge_no_push", 32'(ins_valid1), 32'd0);
    wait_drain(40);

    // Redirect from IDLE, then reset while WAIT; the late response lands in IDLE.
    assert_reset();
    lat = 4; ins_ack = 1'b1;
    push_req(16'h0040, 0);
    push_req(16'h0000, 0);
    push_req(16'h0001, 6);
    push_ins(16'h0000);
    redirect = 1'b1; redirect_pc = 16'h0040;
    rst1 = 1'b0;
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    rst1 = 1'b1;
    #1;
    check("midrst_mem_req", 32'(mem_req1), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr1), 32'd0);
    check("midrst_ins_valid", 32'(ins_valid1), 32'd0);
    repeat (2) tick();
    rst1 = 1'b0;
    wait_drain(60);

    // RESET_PC = 0xFFFE: fetch addresses wrap through 0xFFFF to 0x0000.
    assert_reset();
    sel = 1'b1;
    lat = 1; ins_ack = 1'b1;
    check("rst2_ins_pc", 32'(ins_pc2), 32'd0);
    check("rst2_mem_addr", 32'(mem_addr2), 32'd0);
    push_req(16'hFFFE, 0);
    push_req(16'hFFFF, 3);
    push_req(16'h0000, 3);
    push_req(16'h0001, 3);
    push_ins(16'hFFFE);
    push_ins(16'hFFFF);
    push_ins(16'h0000);
    rst2 = 1'b0;
    wait_drain(40);
    assert_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
